// File: rtl/mod_kg_invexpand_if.sv
// Stream, load and S-box side-port bundle of the reverse AES-256 key-schedule walker.
// The slave modport is the walker; the master modport is its environment.
interface mod_kg_invexpand_if;
    logic                  start;
    logic [7:0][3:0][7:0]  inp_key;
    logic                  busy;
    logic [3:0][7:0]       sbox_word_o;
    logic [3:0][7:0]       sbox_word_i;
    logic [3:0][3:0][7:0]  outp_rk;
    logic [3:0]            outp_round;
    logic                  outp_valid;
    logic                  outp_ready;
    logic                  outp_last;

    modport master (
        output start, inp_key, sbox_word_i, outp_ready,
        input  busy, sbox_word_o, outp_rk, outp_round, outp_valid, outp_last
    );

    modport slave (
        input  start, inp_key, sbox_word_i, outp_ready,
        output busy, sbox_word_o, outp_rk, outp_round, outp_valid, outp_last
    );
endinterface

// File: rtl/mod_kg_invexpand.sv
// Reverse AES-256 key-schedule walker: loads w52..w59 and emits rk14..rk0.
// It undoes one expansion word per cycle using the external S-box.
module mod_kg_invexpand (
    input  logic               clk,
    input  logic               resetn,
    mod_kg_invexpand_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO, STEP} state_t;

    state_t                r_state, w_stateNext;
    logic [3:0][7:0]       r_win [8];
    logic [3:0][7:0]       w_winNext [8];
    logic [5:0]            r_idx, w_idxNext;
    logic [1:0]            r_stepCnt, w_stepCntNext;
    logic [3:0]            r_round, w_roundNext;
    logic [3:0][3:0][7:0]  r_rk, w_rkNext;
    logic                  r_valid, w_validNext;
    logic                  r_last, w_lastNext;
    logic                  r_busy, w_busyNext;

    logic [3:0][7:0]       w_t, w_sboxOut, w_f, w_newWord;
    logic [7:0]            w_rcon;
    logic                  w_fire;

    assign w_t    = r_win[6];
    assign w_fire = r_valid & bus.outp_ready;

    // On Nk-aligned words the lookup needs RotWord; elsewhere the raw word is sent.
    always_comb begin
        w_sboxOut = w_t;
        if (r_idx[2:0] == 3'd0) begin
            w_sboxOut = {w_t[0], w_t[3], w_t[2], w_t[1]};
        end
    end

    always_comb begin
        w_rcon = 8'h00;
        case (r_idx[5:3])
            3'd1:    w_rcon = 8'h01;
            3'd2:    w_rcon = 8'h02;
            3'd3:    w_rcon = 8'h04;
            3'd4:    w_rcon = 8'h08;
            3'd5:    w_rcon = 8'h10;
            3'd6:    w_rcon = 8'h20;
            3'd7:    w_rcon = 8'h40;
            default: w_rcon = 8'h00;
        endcase
    end

    always_comb begin
        w_f = w_t;
        case (r_idx[2:0])
            3'd0: begin
                w_f    = bus.sbox_word_i;
                w_f[0] = bus.sbox_word_i[0] ^ w_rcon;
            end
            3'd4:    w_f = bus.sbox_word_i;
            default: w_f = w_t;
        endcase
    end

    assign w_newWord = r_win[7] ^ w_f;

    always_comb begin
        w_stateNext   = r_state;
        w_winNext     = r_win;
        w_idxNext     = r_idx;
        w_stepCntNext = r_stepCnt;
        w_roundNext   = r_round;
        w_rkNext      = r_rk;
        w_validNext   = r_valid;
        w_lastNext    = r_last;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_stateNext = EMIT_HI;
                    for (int j = 0; j < 8; j++) begin
                        w_winNext[j] = bus.inp_key[j];
                    end
                    for (int k = 0; k < 4; k++) begin
                        w_rkNext[k] = bus.inp_key[4 + k];
                    end
                    w_idxNext   = 6'd59;
                    w_roundNext = 4'd14;
                    w_validNext = 1'b1;
                    w_lastNext  = 1'b0;
                end
            end
            EMIT_HI: begin
                if (w_fire) begin
                    w_stateNext = EMIT_LO;
                    w_roundNext = 4'd13;
                    for (int k = 0; k < 4; k++) begin
                        w_rkNext[k] = r_win[k];
                    end
                end
            end
            EMIT_LO: begin
                if (w_fire) begin
                    w_validNext = 1'b0;
                    w_lastNext  = 1'b0;
                    if (r_round == 4'd0) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_stateNext   = STEP;
                        w_stepCntNext = 2'd0;
                        w_roundNext   = r_round - 4'd1;
                    end
                end
            end
            STEP: begin
                w_winNext[0] = w_newWord;
                for (int j = 1; j < 8; j++) begin
                    w_winNext[j] = r_win[j - 1];
                end
                w_idxNext     = r_idx - 6'd1;
                w_stepCntNext = r_stepCnt + 2'd1;
                // The fourth step completes the next round key, so load it straight into the output register.
                if (r_stepCnt == 2'd3) begin
                    w_stateNext = EMIT_LO;
                    w_rkNext[0] = w_newWord;
                    w_rkNext[1] = r_win[0];
                    w_rkNext[2] = r_win[1];
                    w_rkNext[3] = r_win[2];
                    w_validNext = 1'b1;
                    w_lastNext  = (r_round == 4'd0);
                end
            end
            default: w_stateNext = IDLE;
        endcase
        w_busyNext = (w_stateNext != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= IDLE;
            for (int j = 0; j < 8; j++) begin
                r_win[j] <= '0;
            end
            r_idx     <= '0;
            r_stepCnt <= '0;
            r_round   <= '0;
            r_rk      <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            for (int j = 0; j < 8; j++) begin
                r_win[j] <= w_winNext[j];
            end
            r_idx     <= w_idxNext;
            r_stepCnt <= w_stepCntNext;
            r_round   <= w_roundNext;
            r_rk      <= w_rkNext;
            r_valid   <= w_validNext;
            r_last    <= w_lastNext;
            r_busy    <= w_busyNext;
        end
    end

    assign bus.sbox_word_o = w_sboxOut;
    assign bus.outp_rk     = r_rk;
    assign bus.outp_round  = r_round;
    assign bus.outp_valid  = r_valid;
    assign bus.outp_last   = r_last;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_mod_kg_invexpand.sv
// Scoreboard bench for mod_kg_invexpand: a forward FIPS-197 expansion predicts every round key,
// and a negedge monitor checks handshakes, stall stability and cycle timing.
module tb_mod_kg_invexpand;

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    logic clk;
    logic resetn;
    logic stallMode;

    mod_kg_invexpand_if bus ();

    mod_kg_invexpand dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int           total;
    int           bad;
    int           cyc;
    int           startCyc;
    int           firstHsCyc;
    int           lastHsCyc;
    int           hsCount;
    int           stallCnt;
    logic [31:0]  fwd [60];
    logic [127:0] capRk [16];
    exp_t         sbq [$];
    logic         prevStall;
    logic [132:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box value from its definition: GF(2^8) inverse (b^254) followed by the affine map.
    function automatic logic [7:0] sboxByte(input logic [7:0] b);
        logic [7:0] r, x, v, e;
        r = 8'h01;
        x = b;
        e = 8'hfe;
        for (int n = 0; n < 8; n++) begin
            if (e[n]) r = gmul(r, x);
            x = gmul(x, x);
        end
        v = r;
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord32(input logic [31:0] x);
        return {sboxByte(x[31:24]), sboxByte(x[23:16]), sboxByte(x[15:8]), sboxByte(x[7:0])};
    endfunction

    function automatic logic [31:0] rotWord32(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic logic [31:0] toDut(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {toDut(d), toDut(c), toDut(b), toDut(a)};
    endfunction

    // The bench's S-box, combinational on the DUT's word port; byte 0 sits in bits [7:0].
    function automatic logic [31:0] subWordDut(input logic [31:0] w);
        return {sboxByte(w[31:24]), sboxByte(w[23:16]), sboxByte(w[15:8]), sboxByte(w[7:0])};
    endfunction

    assign bus.sbox_word_i = subWordDut(bus.sbox_word_o);

    task automatic expandKey(input logic [255:0] key);
        logic [31:0] temp;
        for (int i = 0; i < 8; i++) fwd[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = fwd[i - 1];
            if (i % 8 == 0)
                temp = subWord32(rotWord32(temp)) ^ {8'h01 << (i / 8 - 1), 24'h0};
            else if (i % 8 == 4)
                temp = subWord32(temp);
            fwd[i] = fwd[i - 8] ^ temp;
        end
    endtask

    task automatic checkOutput(input string name, input logic [139:0] act, input logic [139:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.outp_ready = stallMode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Monitor: checks stall stability and pops the scoreboard on every handshake.
    always @(negedge clk) begin
        exp_t e;
        if (resetn !== 1'b1) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall)
                checkOutput("stallHold",
                            140'({bus.outp_valid, bus.outp_last, bus.outp_round, bus.outp_rk}),
                            140'({1'b1, held}));
            if (bus.outp_valid === 1'b1 && bus.outp_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpectedHandshake", 140'(1), 140'(0));
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rk", 140'(bus.outp_rk), 140'(e.rk));
                    checkOutput("roundLast", 140'({bus.outp_round, bus.outp_last}),
                                140'({e.round, e.last}));
                    capRk[bus.outp_round] = bus.outp_rk;
                    if (hsCount == 0) firstHsCyc = cyc;
                    lastHsCyc = cyc;
                    hsCount++;
                end
            end
            if (bus.outp_valid === 1'b1 && bus.outp_ready !== 1'b1) stallCnt++;
            prevStall = (bus.outp_valid === 1'b1) && (bus.outp_ready !== 1'b1);
            held = {bus.outp_last, bus.outp_round, bus.outp_rk};
        end
    end

    task automatic loadExpected(input logic [255:0] key);
        exp_t         e;
        logic [255:0] kv;
        expandKey(key);
        sbq.delete();
        for (int r = 14; r >= 0; r--) begin
            for (int k = 0; k < 4; k++) e.rk[32 * k +: 32] = toDut(fwd[4 * r + k]);
            e.round = 4'(r);
            e.last  = (r == 0);
            sbq.push_back(e);
        end
        for (int j = 0; j < 8; j++) kv[32 * j +: 32] = toDut(fwd[52 + j]);
        bus.inp_key = kv;
    endtask

    // Runs one key from its start cycle (the current cycle) until busy falls.
    task automatic applyStimulus(input logic [255:0] key, input bit stall, input bit pulse,
                                 input bit sbCheck);
        int k;
        bit done;
        loadExpected(key);
        hsCount    = 0;
        stallCnt   = 0;
        firstHsCyc = -1;
        lastHsCyc  = -1;
        stallMode  = stall;
        bus.start  = 1'b1;
        startCyc   = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        k    = 1;
        done = 1'b0;
        while (!done && k < 3000) begin
            if (pulse && (k == 5 || k == 40)) begin
                bus.start   = 1'b1;
                bus.inp_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                               $urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                bus.start = 1'b0;
            end
            if (sbCheck && k == 6)
                checkOutput("sboxAtI56", 140'(bus.sbox_word_o), 140'(toDut(rotWord32(fwd[55]))));
            if (sbCheck && k == 11)
                checkOutput("sboxAtI52", 140'(bus.sbox_word_o), 140'(toDut(fwd[51])));
            if (bus.busy !== 1'b1) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        bus.start = 1'b0;
        stallMode = 1'b0;
        checkOutput("busyFallCycle", 140'(k), 140'(68 + stallCnt));
        checkOutput("lastHsCycle", 140'(lastHsCyc - startCyc), 140'(67 + stallCnt));
        checkOutput("scoreboardEmpty", 140'(sbq.size()), 140'(0));
        if (!stall) checkOutput("firstHsCycle", 140'(firstHsCyc - startCyc), 140'(1));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Ctrl"}, 140'({bus.outp_valid, bus.busy, bus.outp_last, bus.outp_round}),
                    140'(0));
        checkOutput({tag, "Rk"}, 140'(bus.outp_rk), 140'(0));
        checkOutput({tag, "Sbox"}, 140'(bus.sbox_word_o), 140'(0));
    endtask

    task automatic midResetTest();
        logic [255:0] keyA, keyB;
        keyA = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        keyB = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        loadExpected(keyA);
        hsCount   = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (29) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        checkAllZero("midReset");
        resetn = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(keyB, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [255:0] a3Key;
        logic [255:0] key;
        total          = 0;
        bad            = 0;
        cyc            = 0;
        prevStall      = 1'b0;
        held           = '0;
        stallMode      = 1'b0;
        resetn         = 1'b0;
        bus.start      = 1'b0;
        bus.inp_key    = '0;
        bus.outp_ready = 1'b1;
        for (int r = 0; r < 16; r++) capRk[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;

        a3Key = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
        $display("[TB] FIPS-197 A.3 walk");
        applyStimulus(a3Key, 1'b0, 1'b0, 1'b1);
        checkOutput("a3Rk1", 140'(capRk[1]),
                    140'(pack4(32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4)));
        checkOutput("a3Rk0", 140'(capRk[0]),
                    140'(pack4(32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781)));

        $display("[TB] ignored start pulses");
        applyStimulus(a3Key, 1'b0, 1'b1, 1'b0);
        $display("[TB] backpressure on A.3 key");
        applyStimulus(a3Key, 1'b1, 1'b0, 1'b0);
        $display("[TB] reset mid-operation");
        midResetTest();

        $display("[TB] random keys against forward expansion");
        for (int n = 0; n < 200; n++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(key, n >= 150, (n % 25 == 3) && (n < 150), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
